i2c_master_arbiter: RTL and testbench

//  Shares one i2c `master` instance between NREQ requesters and sequences each transaction.

---
 rtl/i2c_master_arbiter_if.sv | 29 ++
 rtl/i2c_master_arbiter.sv | 113 +++++++++++
 tb/tb_i2c_master_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_arbiter_if.sv
// Client-side and master-side signal bundle for i2c_master_arbiter.
// slave = arbiter view, master = environment (clients + i2c master) view.
interface i2c_master_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              err;
  logic              busy;
  logic              m_rst;
  logic              m_rw;
  logic [7:0]        m_data_in;
  logic [7:0]        m_data_out;
  logic [3:0]        m_state;

  modport slave (
    input  req, req_rw, req_wdata, m_data_out, m_state,
    output gnt, done, rdata, err, busy, m_rst, m_rw, m_data_in
  );

  modport master (
    output req, req_rw, req_wdata, m_data_out, m_state,
    input  gnt, done, rdata, err, busy, m_rst, m_rw, m_data_in
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one i2c master instance.
// Optional RUN-state abort timer enabled by defining ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CW             = 11
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.slave  bus
);
  localparam int          PW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic            any;
  int unsigned     idx;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NR) idx = idx - NR;
      if (!any && bus.req[idx]) begin
        any  = 1'b1;
        pick = PW'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.m_rst     <= 1'b1;
      bus.m_rw      <= 1'b0;
      bus.m_data_in <= '0;
      rr_ptr        <= '0;
      win           <= '0;
`ifdef ARB_TIMEOUT_EN
      bus.err       <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state         <= GRANT;
            win           <= pick;
            bus.gnt       <= NREQ'(1) << pick;
            bus.m_rw      <= bus.req_rw[pick];
            bus.m_data_in <= bus.req_wdata[8*pick +: 8];
            bus.busy      <= 1'b1;
          end
        end
        GRANT: begin
          state     <= RUN;
          bus.m_rst <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        RUN: begin
          if (bus.m_state == 4'd9) begin
            state     <= DONE;
            bus.done  <= NREQ'(1) << win;
            bus.m_rst <= 1'b1;
            if (bus.m_rw) bus.rdata <= bus.m_data_out;
          end
`ifdef ARB_TIMEOUT_EN
          // STOP seen on the final allowed cycle still completes normally.
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state     <= DONE;
            bus.done  <= NREQ'(1) << win;
            bus.m_rst <= 1'b1;
            bus.err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= '0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          rr_ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef ARB_TIMEOUT_EN
          bus.err  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: fixed vector table, corner sequences and random transactions.
module tb_i2c_master_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_master_arbiter #(
    .NREQ(NREQ),
    .TIMEOUT_CYCLES(TMO),
    .CW(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural i2c master: reaches STOP (9) stop_after cycles after release.
  int   stop_after = 1;
  int   run_cnt    = 0;
  bit   force9     = 0;
  always @(posedge clk) begin
    if (force9) bus.m_state <= 4'd9;
    else if (rst || bus.m_rst !== 1'b0) begin
      run_cnt     <= 0;
      bus.m_state <= 4'd0;
    end else begin
      run_cnt     <= run_cnt + 1;
      bus.m_state <= (run_cnt + 1 >= stop_after) ? 4'd9 : 4'((run_cnt % 8) + 1);
    end
  end

  int         model_rr    = 0;
  logic [7:0] model_rdata = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit aborts(input int stop);
`ifdef ARB_TIMEOUT_EN
    return (stop + 1 > TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(model_rr + i) % NREQ]) return (model_rr + i) % NREQ;
    return -1;
  endfunction

  // Called at a negedge with the DUT idle; leaves it at the following idle negedge.
  task automatic txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] rw,
                     input logic [8*NREQ-1:0] wd, input logic [7:0] dout,
                     input int stop, input bit hold, input int exp_win,
                     input logic [7:0] exp_rd);
    int exp_cyc;
    int c;
    bit seen;
    exp_cyc = aborts(stop) ? TMO : stop + 1;
    bus.req = r; bus.req_rw = rw; bus.req_wdata = wd;
    bus.m_data_out = dout; stop_after = stop;
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(1) << exp_win);
    chk("busy", 32'(bus.busy), 1);
    chk("m_rst_setup", 32'(bus.m_rst), 1);
    chk("m_rw", 32'(bus.m_rw), 32'(rw[exp_win]));
    chk("m_data_in", 32'(bus.m_data_in), 32'(wd[8*exp_win +: 8]));
    if (!hold) begin
      bus.req[exp_win]    = 1'b0;
      bus.req_rw[exp_win] = ~rw[exp_win];
      bus.req_wdata[8*exp_win +: 8] = ~wd[8*exp_win +: 8];
    end
    @(negedge clk);
    chk("m_rst_run", 32'(bus.m_rst), 0);
    c = 0; seen = 0;
    while (!seen && c < exp_cyc + 8) begin
      @(negedge clk);
      c++;
      if (bus.done != '0) seen = 1;
    end
    chk("done_latency", c, exp_cyc);
    if (!seen) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      model_rr = 0; model_rdata = 8'h00;
      return;
    end
    chk("done", 32'(bus.done), 32'(1) << exp_win);
    chk("err", 32'(bus.err), 32'(aborts(stop)));
    chk("rdata", 32'(bus.rdata), 32'(exp_rd));
    chk("m_rst_done", 32'(bus.m_rst), 1);
    chk("m_rw_locked", 32'(bus.m_rw), 32'(rw[exp_win]));
    chk("m_data_in_locked", 32'(bus.m_data_in), 32'(wd[8*exp_win +: 8]));
    @(negedge clk);
    chk("done_clr", 32'(bus.done), 0);
    chk("gnt_clr", 32'(bus.gnt), 0);
    chk("busy_clr", 32'(bus.busy), 0);
    model_rr    = (exp_win + 1) % NREQ;
    model_rdata = exp_rd;
  endtask

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   rw;
    logic [8*NREQ-1:0] wdata;
    logic [7:0]        dout;
    int                stop;
    bit                hold;
    int                exp_win;
    logic [7:0]        exp_rdata;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{2'b01, 2'b01, 16'h0000, 8'hF6, 14, 0, 0, 8'hF6};
    vt[1] = '{2'b10, 2'b00, 16'hA600, 8'h33, 5,  0, 1, 8'hF6};
    vt[2] = '{2'b11, 2'b11, 16'h2211, 8'h10, 3,  1, 0, 8'h10};
    vt[3] = '{2'b11, 2'b11, 16'h2211, 8'h20, 4,  1, 1, 8'h20};
    vt[4] = '{2'b11, 2'b11, 16'h2211, 8'h30, 2,  1, 0, 8'h30};
    vt[5] = '{2'b11, 2'b00, 16'h4455, 8'h99, 6,  1, 1, 8'h30};
    vt[6] = '{2'b10, 2'b10, 16'h0000, 8'h5A, 1,  0, 1, 8'h5A};

    bus.req = '0; bus.req_rw = '0; bus.req_wdata = '0; bus.m_data_out = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_rst", 32'(bus.m_rst), 1);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_m_rw", 32'(bus.m_rw), 0);
    chk("rst_m_data_in", 32'(bus.m_data_in), 0);
    rst = 1'b0;

    // Idle with no request, and a stray STOP code, must not start anything.
    force9 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_m_rst", 32'(bus.m_rst), 1);
    end
    force9 = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      txn(vt[i].req, vt[i].rw, vt[i].wdata, vt[i].dout, vt[i].stop,
          vt[i].hold, vt[i].exp_win, vt[i].exp_rdata);

    // Mid-run reset: rr_ptr is 1 when reset hits, so req=11 afterwards must go to 0.
    txn(2'b01, 2'b01, 16'h0000, 8'hC3, 4, 0, 0, 8'hC3);
    bus.req = 2'b01; bus.req_rw = 2'b01; bus.m_data_out = 8'hEE; stop_after = 1000;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    chk("mrst_gnt", 32'(bus.gnt), 0);
    chk("mrst_m_rst", 32'(bus.m_rst), 1);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_rdata", 32'(bus.rdata), 0);
    model_rr = 0; model_rdata = 8'h00;
    @(negedge clk);
    chk("mrst_no_done", 32'(bus.done), 0);
    txn(2'b11, 2'b00, 16'h1234, 8'h00, 3, 1, 0, 8'h00);

`ifdef ARB_TIMEOUT_EN
    txn(2'b01, 2'b01, 16'h0000, 8'h77, 1000, 0, rr_pick(2'b01), model_rdata);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [NREQ-1:0]   r;
      logic [NREQ-1:0]   rw;
      logic [8*NREQ-1:0] wd;
      logic [7:0]        dout;
      int                stop;
      int                w;
      r    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rw   = NREQ'($urandom);
      wd   = (8*NREQ)'($urandom);
      dout = 8'($urandom);
      stop = $urandom_range(1, 20);
      w    = rr_pick(r);
      txn(r, rw, wd, dout, stop, 1'($urandom), w,
          (rw[w] && !aborts(stop)) ? dout : model_rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
